io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder_pkg.sv | 32 +++
 rtl/io_responder_uart_tx.sv | 93 +++++++++
 rtl/io_responder.sv | 121 ++++++++++++
 tb/tb_io_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// Shared constants for the memory-visit IO responder: status, access type/size encodings,
// register addresses and the FSM state types.
package io_responder_pkg;

  localparam logic [1:0] STATUS_IDLE = 2'b00;
  localparam logic [1:0] STATUS_BUSY = 2'b01;
  localparam logic [1:0] STATUS_DONE = 2'b10;

  localparam logic [1:0] VIS_NONE  = 2'b00;
  localparam logic [1:0] VIS_READ  = 2'b01;
  localparam logic [1:0] VIS_WRITE = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [16:0] ADDR_TXDATA  = 17'h10000;
  localparam logic [16:0] ADDR_STATUS  = 17'h10004;
  localparam logic [16:0] ADDR_TXCOUNT = 17'h10008;

  typedef enum logic [1:0] {RSP_IDLE, RSP_WAIT_SPACE, RSP_DONE} rsp_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  function automatic logic [1:0] status_of(input rsp_state_e s);
    case (s)
      RSP_WAIT_SPACE: return STATUS_BUSY;
      RSP_DONE:       return STATUS_DONE;
      default:        return STATUS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/io_responder_uart_tx.sv
// 8N1 serializer fed by a valid/ready pop handshake. States: TX_IDLE line high | TX_START start bit |
// TX_DATA 8 data bits LSB first | TX_STOP stop bit, may chain straight into the next START.
module uart_tx
  import io_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_active,
  output logic       o_tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign o_active  = (r_state != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    o_ready     = 1'b0;
    o_tx        = 1'b1;
    case (r_state)
      TX_IDLE: begin
        o_ready    = 1'b1;
        w_baud_nxt = '0;
        if (i_valid) begin
          w_shift_nxt = i_data;
          w_state_nxt = TX_START;
        end
      end
      TX_START: begin
        o_tx = 1'b0;
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        o_tx = r_shift[0];
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = TX_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          // Pop at the stop-bit boundary so a queued byte follows with no idle bit.
          o_ready    = 1'b1;
          w_baud_nxt = '0;
          if (i_valid) begin
            w_shift_nxt = i_data;
            w_state_nxt = TX_START;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/io_responder.sv
// Memory-visit responder: TXDATA/STATUS/TXCOUNT register window over a byte FIFO feeding uart_tx.
// States: RSP_IDLE accepting | RSP_WAIT_SPACE FIFO full, write held | RSP_DONE one-cycle completion.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int LEN            = 32,
  parameter int ADDR_WIDTH     = 17,
  parameter int SYS_CLK_FREQ   = 100000000,
  parameter int UART_BAUD_RATE = 115200,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_data_addr,
  input  logic                  mem_vis_enabled,
  input  logic [1:0]            memory_vis_signal,
  input  logic [1:0]            memory_vis_data_size,
  input  logic [LEN-1:0]        mem_write_data,
  output logic [LEN-1:0]        mem_read_data,
  output logic [1:0]            mem_vis_status,
  output logic                  Tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  rsp_state_e       r_state, w_state_nxt;
  logic [1:0]       r_status;
  logic [LEN-1:0]   r_read_data, w_read_data_nxt;
  logic [7:0]       r_wdata, w_push_data;
  logic             w_push, w_pop, w_full, w_empty, w_tx_ready, w_tx_active, w_accept;
  logic             w_hit_tx, w_hit_status, w_hit_count;
  logic             w_unused;

  assign w_unused     = ^{memory_vis_data_size, mem_write_data[LEN-1:8]};
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_pop        = w_tx_ready && !w_empty;
  assign w_accept     = (r_state == RSP_IDLE) && mem_vis_enabled && (memory_vis_signal != VIS_NONE);
  assign w_hit_tx     = (mem_data_addr == ADDR_WIDTH'(ADDR_TXDATA));
  assign w_hit_status = (mem_data_addr == ADDR_WIDTH'(ADDR_STATUS));
  assign w_hit_count  = (mem_data_addr == ADDR_WIDTH'(ADDR_TXCOUNT));

  assign mem_read_data  = r_read_data;
  assign mem_vis_status = r_status;

  always_comb begin
    w_state_nxt     = r_state;
    w_read_data_nxt = r_read_data;
    w_push          = 1'b0;
    w_push_data     = mem_write_data[7:0];
    case (r_state)
      RSP_IDLE: begin
        if (w_accept) begin
          w_state_nxt = RSP_DONE;
          if (memory_vis_signal == VIS_READ) begin
            if (w_hit_status)     w_read_data_nxt = LEN'({w_tx_active, w_empty, w_full});
            else if (w_hit_count) w_read_data_nxt = LEN'(r_count);
            else                  w_read_data_nxt = '0;
          end else if (memory_vis_signal == VIS_WRITE && w_hit_tx) begin
            if (w_full) w_state_nxt = RSP_WAIT_SPACE;
            else        w_push      = 1'b1;
          end
        end
      end
      RSP_WAIT_SPACE: begin
        // Judged on the registered count: a same-cycle pop does not free space yet.
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_data = r_wdata;
          w_state_nxt = RSP_DONE;
        end
      end
      default: w_state_nxt = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RSP_IDLE;
      r_status    <= STATUS_IDLE;
      r_read_data <= '0;
      r_wdata     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_status    <= status_of(w_state_nxt);
      r_read_data <= w_read_data_nxt;
      if (w_accept) r_wdata <= mem_write_data[7:0];
      if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end

  uart_tx #(
    .CLKS_PER_BIT(SYS_CLK_FREQ / UART_BAUD_RATE)
  ) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst),
    .i_valid (!w_empty),
    .i_data  (r_fifo[r_rd_ptr]),
    .o_ready (w_tx_ready),
    .o_active(w_tx_active),
    .o_tx    (Tx)
  );

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: register window, FIFO back-pressure, UART framing and reset abort.
module tb_io_responder;

  localparam int BIT = 868;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] mem_data_addr;
  logic        mem_vis_enabled;
  logic [1:0]  memory_vis_signal;
  logic [1:0]  memory_vis_data_size;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [1:0]  mem_vis_status;
  logic        Tx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  io_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_data_addr       (mem_data_addr),
    .mem_vis_enabled     (mem_vis_enabled),
    .memory_vis_signal   (memory_vis_signal),
    .memory_vis_data_size(memory_vis_data_size),
    .mem_write_data      (mem_write_data),
    .mem_read_data       (mem_read_data),
    .mem_vis_status      (mem_vis_status),
    .Tx                  (Tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request, wait for DONE, drop the request in DONE and return on the next (IDLE) cycle.
  task automatic vis_req(input logic [1:0] sig, input logic [16:0] addr, input logic [31:0] wdata,
                         output int lat, output bit saw_busy, output logic [31:0] rd);
    mem_data_addr        = addr;
    memory_vis_signal    = sig;
    mem_write_data       = wdata;
    memory_vis_data_size = 2'b10;
    mem_vis_enabled      = 1'b1;
    lat = 0;
    saw_busy = 1'b0;
    do begin
      step(1);
      lat++;
      if (mem_vis_status == 2'b01) saw_busy = 1'b1;
    end while (mem_vis_status != 2'b10 && lat < 20000);
    rd = mem_read_data;
    mem_vis_enabled   = 1'b0;
    memory_vis_signal = 2'b00;
    step(1);
  endtask

  task automatic do_write(input string tag, input logic [16:0] addr, input logic [31:0] wdata);
    int lat;
    bit busy;
    logic [31:0] rd;
    vis_req(2'b10, addr, wdata, lat, busy, rd);
    check_eq(tag, lat, 1);
  endtask

  task automatic do_read(input string tag, input logic [16:0] addr, input logic [31:0] exp);
    int lat;
    bit busy;
    logic [31:0] rd;
    vis_req(2'b01, addr, 32'h0, lat, busy, rd);
    check_eq({tag, "_lat"}, lat, 1);
    check_eq(tag, rd, exp);
  endtask

  task automatic wait_tx(input logic level, input int bound, output int n);
    n = 0;
    while (Tx !== level && n < bound) begin
      step(1);
      n++;
    end
  endtask

  task automatic run_len(input logic level, input int bound, output int n);
    n = 0;
    while (Tx === level && n < bound) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int lat;
    bit busy;
    logic [31:0] rd;
    logic [7:0] pat;

    rst = 1'b0;
    mem_vis_enabled = 1'b0;
    memory_vis_signal = 2'b00;
    memory_vis_data_size = 2'b00;
    mem_data_addr = '0;
    mem_write_data = '0;
    #23;
    check_eq("rst_status", mem_vis_status, 2'b00);
    check_eq("rst_rdata", mem_read_data, 32'h0);
    check_eq("rst_tx", Tx, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2);

    // Register reads while idle
    do_read("status_idle", 17'h10004, 32'h2);
    do_read("txcount_idle", 17'h10008, 32'h0);
    do_read("status_idle2", 17'h10004, 32'h2);
    do_read("unmapped_rd", 17'h00123, 32'h0);

    // Single frame 0x55
    do_write("tx55_wr", 17'h10000, 32'h00000055);
    wait_tx(1'b0, 10, n);
    check_eq("tx55_start_lat", n, 0);
    run_len(1'b0, 20000, n);
    check_eq("tx55_start_len", n, BIT);
    pat = 8'h55;
    step(BIT / 2);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("tx55_bit%0d", i), Tx, pat[i]);
      step(BIT);
    end
    check_eq("tx55_stop", Tx, 1'b1);
    step(BIT);
    check_eq("tx55_idle", Tx, 1'b1);
    do_read("status_after55", 17'h10004, 32'h2);

    // Back-pressure: one frame in flight, then fill the FIFO
    do_write("stall_first", 17'h10000, 32'h000000A5);
    check_eq("stall_tx_active", Tx, 1'b0);
    for (int i = 0; i < 8; i++)
      do_write($sformatf("stall_wr%0d", i), 17'h10000, 32'h12345600);
    do_write("unmapped_wr_full", 17'h00123, 32'h00000077);
    do_read("txcount_full", 17'h10008, 32'h8);
    do_read("status_full", 17'h10004, 32'h5);
    do_read("unmapped_rd2", 17'h00123, 32'h0);
    vis_req(2'b10, 17'h10000, 32'h00000000, lat, busy, rd);
    check_eq("ninth_busy", busy, 1'b1);
    check_eq("ninth_waited", (lat > 1000 && lat < 8700), 1'b1);
    do_read("txcount_after_pop", 17'h10008, 32'h8);

    // Reset mid-frame with data bits low on the line
    step(BIT * 4);
    check_eq("pre_rst_tx", Tx, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_tx", Tx, 1'b1);
    check_eq("midrst_status", mem_vis_status, 2'b00);
    check_eq("midrst_rdata", mem_read_data, 32'h0);
    step(1);
    rst = 1'b1;
    step(1);
    do_read("txcount_after_rst", 17'h10008, 32'h0);
    do_read("status_after_rst", 17'h10004, 32'h2);

    // Reset at bit 4 with 3 bytes queued
    for (int i = 0; i < 4; i++)
      do_write($sformatf("q3_wr%0d", i), 17'h10000, 32'h00000000);
    step(BIT * 5 + 100);
    check_eq("q3_pre_rst_tx", Tx, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("q3_rst_tx", Tx, 1'b1);
    check_eq("q3_rst_status", mem_vis_status, 2'b00);
    step(1);
    rst = 1'b1;
    step(1);
    do_read("q3_txcount", 17'h10008, 32'h0);
    step(5);
    check_eq("q3_tx_stays_idle", Tx, 1'b1);

    // Back-to-back writes give contiguous frames
    do_write("b2b_wr0", 17'h10000, 32'h000000FF);
    do_write("b2b_wr1", 17'h10000, 32'h00000000);
    wait_tx(1'b1, 2000, n);
    check_eq("b2b_first_data_seen", Tx, 1'b1);
    run_len(1'b1, 20000, n);
    check_eq("b2b_high_run", n, 9 * BIT);
    run_len(1'b0, 20000, n);
    check_eq("b2b_low_run", n, 9 * BIT);
    step(BIT / 2);
    check_eq("b2b_stop", Tx, 1'b1);
    step(BIT);
    check_eq("b2b_idle", Tx, 1'b1);
    do_read("b2b_status_end", 17'h10004, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
